// File: rtl/bus_pkg.sv
// Shared system-bus definitions: slave-device field width, serial-bus mode
// encoding and the slave_port state encoding.
package bus_pkg;

  localparam int SLAVE_DEVICE_ADDR_WIDTH = 4;
  localparam int CNT_W = 8;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } bus_mode_e;

  typedef enum logic [2:0] {
    SP_IDLE  = 3'd0,
    SP_ADDR  = 3'd1,
    SP_WDATA = 3'd2,
    SP_MREQ  = 3'd3,
    SP_RDATA = 3'd4
  } sp_state_e;

endpackage

// File: rtl/slave_port_deser.sv
// Counter-indexed serial capture: bit idx_i of data lands in data_o[idx_i].
// done_o pulses when the last bit position is captured.
module serial_deser
  import bus_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [CNT_W-1:0] idx_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] data_o,
  output logic             done_o
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (en_i && (idx_i == CNT_W'(i))) data_d[i] = bit_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data_o = data_q;
  assign done_o = en_i && (idx_i == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/slave_port.sv
// Serial-bus slave endpoint: shifts in address (and write data), issues one
// valid/ready request to the device, and serialises read data back.
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 16 - SLAVE_DEVICE_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] daddr,
  output logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dmode,
  output logic                  dvalid,
  input  logic                  dready,
  input  logic [DATA_WIDTH-1:0] drdata,
  output sp_state_e             dbg_state_o
);

  // Device handshake: a request is transferred on a cycle where dvalid and
  // dready are both high; dvalid, daddr, dwdata and dmode hold until then.

  sp_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;

  logic                  addr_en, addr_done;
  logic                  data_en, data_done;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [DATA_WIDTH-1:0] wdata_w;
  logic [DATA_WIDTH-1:0] rshift;

  assign addr_en = mvalid && ((state_q == SP_IDLE) || (state_q == SP_ADDR));
  assign data_en = mvalid && (state_q == SP_WDATA);

  serial_deser #(.WIDTH(ADDR_WIDTH)) u_addr (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (addr_en),
    .idx_i  (cnt_q),
    .bit_i  (swdata),
    .data_o (addr_w),
    .done_o (addr_done)
  );

  serial_deser #(.WIDTH(DATA_WIDTH)) u_wdata (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (data_en),
    .idx_i  (cnt_q),
    .bit_i  (swdata),
    .data_o (wdata_w),
    .done_o (data_done)
  );

  assign rshift = rdata_q >> cnt_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    rdata_d  = rdata_q;
    srdata_d = srdata_q;
    svalid_d = svalid_q;
    case (state_q)
      SP_IDLE: begin
        cnt_d = '0;
        if (mvalid) begin
          cnt_d   = CNT_W'(1);
          state_d = SP_ADDR;
        end
      end
      SP_ADDR: begin
        if (mvalid) begin
          if (addr_done) begin
            mode_d  = smode;
            cnt_d   = '0;
            state_d = (smode == MODE_WRITE) ? SP_WDATA : SP_MREQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SP_WDATA: begin
        if (mvalid) begin
          if (data_done) begin
            cnt_d   = '0;
            state_d = SP_MREQ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SP_MREQ: begin
        if (dready) begin
          if (mode_q == MODE_WRITE) begin
            state_d = SP_IDLE;
          end else begin
            // Bit 0 goes out with the handshake so svalid starts next cycle.
            rdata_d  = drdata;
            srdata_d = drdata[0];
            svalid_d = 1'b1;
            cnt_d    = CNT_W'(1);
            state_d  = SP_RDATA;
          end
        end
      end
      SP_RDATA: begin
        if (cnt_q == CNT_W'(DATA_WIDTH)) begin
          svalid_d = 1'b0;
          cnt_d    = '0;
          state_d  = SP_IDLE;
        end else begin
          srdata_d = rshift[0];
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = SP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= SP_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      rdata_q  <= '0;
      srdata_q <= 1'b0;
      svalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      rdata_q  <= rdata_d;
      srdata_q <= srdata_d;
      svalid_q <= svalid_d;
    end
  end

  assign srdata      = srdata_q;
  assign svalid      = svalid_q;
  assign sready      = (state_q == SP_IDLE);
  assign dvalid      = (state_q == SP_MREQ);
  assign daddr       = addr_w;
  assign dwdata      = wdata_w;
  assign dmode       = mode_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port: write, read, backpressure, mvalid gaps,
// reset mid-transfer and back-to-back write/read.
module tb_slave_port;
  import bus_pkg::*;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn, swdata, smode, mvalid, dready;
  logic          srdata, svalid, sready, dmode, dvalid;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata, drdata, drdata_drv;
  sp_state_e     dbg_state;

  logic          use_model;
  logic [AW-1:0] model_addr;
  logic [DW-1:0] model_data;

  int checks   = 0;
  int failures = 0;

  assign drdata = use_model ? ((daddr == model_addr) ? model_data : 8'h00) : drdata_drv;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .swdata      (swdata),
    .smode       (smode),
    .mvalid      (mvalid),
    .srdata      (srdata),
    .svalid      (svalid),
    .sready      (sready),
    .daddr       (daddr),
    .dwdata      (dwdata),
    .dmode       (dmode),
    .dvalid      (dvalid),
    .dready      (dready),
    .drdata      (drdata),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shift n bits of v LSB first; optional idle gap of gap_len after every gap_every bits.
  task automatic send_bits(input logic [15:0] v, input int n, input int gap_every, input int gap_len);
    for (int i = 0; i < n; i++) begin
      mvalid = 1'b1;
      swdata = v[i];
      tick();
      mvalid = 1'b0;
      swdata = 1'b0;
      if (gap_every > 0 && ((i + 1) % gap_every) == 0 && i < n - 1) begin
        repeat (gap_len) begin
          check("gap_dvalid_low", 32'(dvalid), 32'd0);
          tick();
        end
      end
    end
  endtask

  // Collect DW serial bits; every cycle must carry svalid.
  task automatic read_serial(input string tag, output logic [DW-1:0] got);
    got = '0;
    for (int i = 0; i < DW; i++) begin
      check({tag, "_svalid"}, 32'(svalid), 32'd1);
      got[i] = srdata;
      tick();
    end
  endtask

  logic [DW-1:0] got;

  initial begin
    rstn = 1'b0; swdata = 1'b0; smode = 1'b0; mvalid = 1'b0;
    dready = 1'b0; drdata_drv = '0; use_model = 1'b0;
    model_addr = '0; model_data = '0;
    #1;
    tick(); tick();
    check("rst_sready", 32'(sready), 32'd1);
    check("rst_svalid", 32'(svalid), 32'd0);
    check("rst_srdata", 32'(srdata), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_daddr",  32'(daddr),  32'd0);
    check("rst_dwdata", 32'(dwdata), 32'd0);
    check("rst_dmode",  32'(dmode),  32'd0);
    rstn = 1'b1;
    tick();

    // Write 0xA5C / 0x3C
    smode = 1'b1; dready = 1'b1;
    send_bits(16'h0A5C, AW, 0, 0);
    check("wr_dvalid_during_data", 32'(dvalid), 32'd0);
    check("wr_sready_busy", 32'(sready), 32'd0);
    send_bits(16'h003C, DW, 0, 0);
    check("wr_dvalid", 32'(dvalid), 32'd1);
    check("wr_daddr",  32'(daddr),  32'h0A5C);
    check("wr_dwdata", 32'(dwdata), 32'h3C);
    check("wr_dmode",  32'(dmode),  32'd1);
    tick();
    check("wr_dvalid_one_cycle", 32'(dvalid), 32'd0);
    check("wr_sready_after", 32'(sready), 32'd1);

    // Read 0x123 returning 0xB6
    smode = 1'b0; dready = 1'b1; drdata_drv = 8'hB6;
    send_bits(16'h0123, AW, 0, 0);
    check("rd_dvalid", 32'(dvalid), 32'd1);
    check("rd_dmode",  32'(dmode),  32'd0);
    check("rd_daddr",  32'(daddr),  32'h123);
    check("rd_dwdata_held", 32'(dwdata), 32'h3C);
    check("rd_svalid_before", 32'(svalid), 32'd0);
    tick();
    check("rd_dvalid_drop", 32'(dvalid), 32'd0);
    read_serial("rd", got);
    check("rd_data", 32'(got), 32'hB6);
    check("rd_svalid_end", 32'(svalid), 32'd0);
    check("rd_sready_end", 32'(sready), 32'd1);

    // Backpressure read of 0x0FF; mvalid toggling in MREQ must be ignored
    dready = 1'b0; drdata_drv = 8'h81;
    send_bits(16'h00FF, AW, 0, 0);
    for (int i = 0; i < 5; i++) begin
      mvalid = 1'b1; swdata = ~swdata;
      check("bp_dvalid", 32'(dvalid), 32'd1);
      check("bp_daddr",  32'(daddr),  32'h0FF);
      check("bp_dmode",  32'(dmode),  32'd0);
      check("bp_svalid", 32'(svalid), 32'd0);
      tick();
    end
    mvalid = 1'b0; dready = 1'b1;
    check("bp_dvalid_6th", 32'(dvalid), 32'd1);
    check("bp_daddr_6th",  32'(daddr),  32'h0FF);
    tick();
    dready = 1'b0;
    read_serial("bp", got);
    check("bp_data", 32'(got), 32'h81);
    check("bp_sready_end", 32'(sready), 32'd1);

    // Write 0x801 / 0x5A with 3-cycle gaps after every 2nd bit
    smode = 1'b1; dready = 1'b1;
    send_bits(16'h0801, AW, 2, 3);
    send_bits(16'h005A, DW, 2, 3);
    check("gap_dvalid", 32'(dvalid), 32'd1);
    check("gap_daddr",  32'(daddr),  32'h801);
    check("gap_dwdata", 32'(dwdata), 32'h5A);
    check("gap_dmode",  32'(dmode),  32'd1);
    tick();
    check("gap_sready_after", 32'(sready), 32'd1);

    // Reset after 6 address bits
    send_bits(16'h0004, 6, 0, 0);
    rstn = 1'b0;
    tick();
    check("mrst_sready", 32'(sready), 32'd1);
    check("mrst_dvalid", 32'(dvalid), 32'd0);
    check("mrst_daddr",  32'(daddr),  32'd0);
    check("mrst_dwdata", 32'(dwdata), 32'd0);
    check("mrst_dmode",  32'(dmode),  32'd0);
    check("mrst_svalid", 32'(svalid), 32'd0);
    rstn = 1'b1;
    tick();
    check("mrst_dvalid_after", 32'(dvalid), 32'd0);
    send_bits(16'h0004, AW, 0, 0);
    send_bits(16'h00FF, DW, 0, 0);
    check("post_dvalid", 32'(dvalid), 32'd1);
    check("post_daddr",  32'(daddr),  32'h004);
    check("post_dwdata", 32'(dwdata), 32'hFF);
    tick();

    // Back-to-back write then read through a model device
    use_model = 1'b1; model_addr = 12'h010; model_data = 8'h77;
    smode = 1'b1; dready = 1'b1;
    send_bits(16'h0010, AW, 0, 0);
    send_bits(16'h0077, DW, 0, 0);
    check("b2b_wr_dvalid", 32'(dvalid), 32'd1);
    check("b2b_wr_daddr",  32'(daddr),  32'h010);
    check("b2b_wr_dwdata", 32'(dwdata), 32'h77);
    tick();
    check("b2b_sready", 32'(sready), 32'd1);
    smode = 1'b0;
    send_bits(16'h0010, AW, 0, 0);
    check("b2b_rd_dvalid", 32'(dvalid), 32'd1);
    check("b2b_rd_dmode",  32'(dmode),  32'd0);
    check("b2b_rd_daddr",  32'(daddr),  32'h010);
    tick();
    read_serial("b2b", got);
    check("b2b_rd_data", 32'(got), 32'h77);
    check("b2b_sready_end", 32'(sready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
